// File: rtl/prog_sequencer.sv
// prog_sequencer: fetch/issue sequencer between a small async-read program ROM
// and the processor controller. Handles mvi immediates, halt, illegal opcodes,
// a Done watchdog and start/stop control.
module prog_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [8:0]        MemData,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [7:0]        InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALT, S_ERR
  } state_t;

  localparam logic [2:0] OP_MVI  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        wd;
  logic              stop_pend;
  logic              busy_st;

  assign busy_st    = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
  assign MemAddr    = pc;
  assign Busy       = busy_st;
  assign Halted     = (state == S_HALT);
  assign Error      = (state == S_ERR);

  // Sequencer FSM: PC, issued word, Run pulse, watchdog, stop latch and counter.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      pc         <= '0;
      DIN        <= '0;
      Run        <= 1'b0;
      wd         <= '0;
      stop_pend  <= 1'b0;
      InstrCount <= '0;
    end else begin
      // Stop is latched while busy; the in-flight instruction still completes.
      if (Stop && busy_st) stop_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          Run <= 1'b0;
          if (Start && !Stop) state <= S_FETCH;
        end
        S_FETCH: begin
          if (MemData[8:6] == OP_HALT) begin
            state     <= S_HALT;
            stop_pend <= 1'b0;
          end else if (MemData[8]) begin
            // 100/101/110 are not defined opcodes; PC stays on the offender.
            state     <= S_ERR;
            stop_pend <= 1'b0;
          end else begin
            DIN   <= MemData;
            Run   <= 1'b1;
            pc    <= pc + 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          Run <= 1'b0;
          // mvi: swap in the immediate word, which sits at the already-bumped PC.
          if (DIN[8:6] == OP_MVI) begin
            DIN <= MemData;
            pc  <= pc + 1'b1;
          end
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (Done) begin
            if (InstrCount != 8'hFF) InstrCount <= InstrCount + 8'd1;
            if (stop_pend || Stop) begin
              state     <= S_IDLE;
              stop_pend <= 1'b0;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            wd <= wd + 8'd1;
            if (wd == WD_LAST) begin
              state     <= S_ERR;
              stop_pend <= 1'b0;
            end
          end
        end
        S_HALT, S_ERR: begin
          if (Start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer. The bench plays the controller (Done)
// and owns two ROM images: one 32-word (ADDR_W=5) and one 4-word (ADDR_W=2).
module tb_prog_sequencer;

  logic       Clock = 1'b0;
  logic       Resetn, Start, Stop, Done;
  logic [4:0] addr1;
  logic [1:0] addr2;
  logic [8:0] data1, data2, din1, din2;
  logic       run1, run2, busy1, busy2, halt1, halt2, err1, err2;
  logic [7:0] cnt1, cnt2;
  logic [8:0] rom1 [32];
  logic [8:0] rom2 [4];

  int n_chk = 0;
  int n_fail = 0;

  assign data1 = rom1[addr1];
  assign data2 = rom2[addr2];

  always #5 Clock = ~Clock;

  prog_sequencer #(.ADDR_W(5), .TIMEOUT(15)) u_dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .MemAddr(addr1), .MemData(data1), .DIN(din1), .Run(run1), .Done(Done),
    .Busy(busy1), .Halted(halt1), .Error(err1), .InstrCount(cnt1)
  );

  prog_sequencer #(.ADDR_W(2), .TIMEOUT(15)) u_dut2 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .MemAddr(addr2), .MemData(data2), .DIN(din2), .Run(run2), .Done(Done),
    .Busy(busy2), .Halted(halt2), .Error(err2), .InstrCount(cnt2)
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Resetn = 1'b0; Start = 1'b0; Stop = 1'b0; Done = 1'b0;
    foreach (rom1[i]) rom1[i] = 9'h000;
    foreach (rom2[i]) rom2[i] = 9'h000;
    tick();
    Resetn = 1'b1;
  endtask

  // Pulse Done for one cycle.
  task automatic pulse_done();
    Done = 1'b1;
    tick();
    Done = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    do_reset();
    Resetn = 1'b0;
    #1;
    chk("rst_addr", 16'(addr1), 16'h0);
    chk("rst_din", 16'(din1), 16'h0);
    chk("rst_run", 16'(run1), 16'h0);
    chk("rst_busy", 16'(busy1), 16'h0);
    chk("rst_halt", 16'(halt1), 16'h0);
    chk("rst_err", 16'(err1), 16'h0);
    chk("rst_cnt", 16'(cnt1), 16'h0);

    // ---- 1: add then halt ----
    do_reset();
    rom1[0] = 9'h05C; rom1[1] = 9'h1C0;
    tick();
    chk("t1_idle_busy", 16'(busy1), 16'h0);
    Start = 1'b1; tick(); Start = 1'b0;          // FETCH
    chk("t1_fetch_busy", 16'(busy1), 16'h1);
    chk("t1_fetch_run", 16'(run1), 16'h0);
    tick();                                      // ISSUE
    chk("t1_run", 16'(run1), 16'h1);
    chk("t1_din", 16'(din1), 16'h05C);
    chk("t1_addr_iss", 16'(addr1), 16'h1);
    tick();                                      // WAIT
    chk("t1_run_low", 16'(run1), 16'h0);
    chk("t1_din_hold", 16'(din1), 16'h05C);
    tick(); tick();
    pulse_done();                                // -> FETCH
    chk("t1_cnt", 16'(cnt1), 16'h1);
    chk("t1_run_wait", 16'(run1), 16'h0);
    tick();                                      // -> HALT
    chk("t1_halted", 16'(halt1), 16'h1);
    chk("t1_addr", 16'(addr1), 16'h1);
    chk("t1_busy", 16'(busy1), 16'h0);
    pulse_done();                                // Done outside WAIT ignored
    chk("t1_cnt_ign", 16'(cnt1), 16'h1);

    // ---- 2: mvi ----
    do_reset();
    rom1[0] = 9'h0E8; rom1[1] = 9'h0A5; rom1[2] = 9'h1C0;
    Start = 1'b1; tick(); Start = 1'b0;
    tick();                                      // ISSUE
    chk("t2_din_op", 16'(din1), 16'h0E8);
    chk("t2_run", 16'(run1), 16'h1);
    tick();                                      // WAIT
    chk("t2_din_imm", 16'(din1), 16'h0A5);
    chk("t2_run_low", 16'(run1), 16'h0);
    chk("t2_addr_w", 16'(addr1), 16'h2);
    tick();
    chk("t2_din_hold", 16'(din1), 16'h0A5);
    pulse_done();                                // FETCH @2
    chk("t2_addr", 16'(addr1), 16'h2);
    tick();
    chk("t2_halted", 16'(halt1), 16'h1);
    chk("t2_cnt", 16'(cnt1), 16'h1);

    // ---- 3: illegal opcode and restart ----
    do_reset();
    rom1[0] = 9'h00A; rom1[1] = 9'h140;
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); tick();                              // ISSUE, WAIT
    pulse_done();                                // FETCH @1
    tick();                                      // ERR
    chk("t3_err", 16'(err1), 16'h1);
    chk("t3_addr", 16'(addr1), 16'h1);
    chk("t3_busy", 16'(busy1), 16'h0);
    Start = 1'b1; tick(); Start = 1'b0;          // FETCH @0
    chk("t3_err_clr", 16'(err1), 16'h0);
    chk("t3_addr_rst", 16'(addr1), 16'h0);
    tick();
    chk("t3_restart_din", 16'(din1), 16'h00A);
    chk("t3_restart_run", 16'(run1), 16'h1);

    // ---- 4: watchdog timeout ----
    do_reset();
    rom1[0] = 9'h05C; rom1[1] = 9'h1C0;
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); tick();                              // entered WAIT
    repeat (14) tick();
    chk("t4_no_err_14", 16'(err1), 16'h0);
    chk("t4_busy_14", 16'(busy1), 16'h1);
    tick();
    chk("t4_err_15", 16'(err1), 16'h1);
    chk("t4_cnt", 16'(cnt1), 16'h0);
    // variant: Done on the terminal cycle wins
    do_reset();
    rom1[0] = 9'h05C; rom1[1] = 9'h1C0;
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); tick();
    repeat (14) tick();
    pulse_done();
    chk("t4v_no_err", 16'(err1), 16'h0);
    chk("t4v_cnt", 16'(cnt1), 16'h1);
    tick();
    chk("t4v_halted", 16'(halt1), 16'h1);

    // ---- 5: stop / resume ----
    do_reset();
    rom1[0] = 9'h00A; rom1[1] = 9'h011; rom1[2] = 9'h01B; rom1[3] = 9'h1C0;
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); tick();                              // WAIT
    Stop = 1'b1; tick(); Stop = 1'b0;
    chk("t5_busy_wait", 16'(busy1), 16'h1);
    tick();
    pulse_done();                                // -> IDLE
    chk("t5_idle_busy", 16'(busy1), 16'h0);
    chk("t5_addr", 16'(addr1), 16'h1);
    chk("t5_cnt", 16'(cnt1), 16'h1);
    tick();
    chk("t5_stay_idle", 16'(busy1), 16'h0);
    Start = 1'b1; Stop = 1'b1; tick(); tick();
    chk("t5_both_idle", 16'(busy1), 16'h0);
    Stop = 1'b0; tick(); Start = 1'b0;           // FETCH @1
    chk("t5_resume_busy", 16'(busy1), 16'h1);
    tick();
    chk("t5_resume_din", 16'(din1), 16'h011);
    chk("t5_resume_addr", 16'(addr1), 16'h2);

    // ---- 6: ADDR_W=2 wrap on mvi immediate, async reset mid-WAIT ----
    do_reset();
    rom2[0] = 9'h00A; rom2[1] = 9'h00A; rom2[2] = 9'h00A; rom2[3] = 9'h0E8;
    Start = 1'b1; tick(); Start = 1'b0;          // FETCH @0
    repeat (3) begin
      tick(); tick();                            // ISSUE, WAIT
      pulse_done();                              // FETCH next
    end
    chk("t6_addr3", 16'(addr2), 16'h3);
    rom2[0] = 9'h1FF;
    tick();                                      // ISSUE mvi
    chk("t6_din_op", 16'(din2), 16'h0E8);
    chk("t6_addr_wrap", 16'(addr2), 16'h0);
    tick();                                      // WAIT
    chk("t6_imm", 16'(din2), 16'h1FF);
    chk("t6_addr1", 16'(addr2), 16'h1);
    chk("t6_cnt", 16'(cnt2), 16'h3);
    #2 Resetn = 1'b0;
    #1;
    chk("t6_rst_din", 16'(din2), 16'h0);
    chk("t6_rst_addr", 16'(addr2), 16'h0);
    chk("t6_rst_busy", 16'(busy2), 16'h0);
    chk("t6_rst_run", 16'(run2), 16'h0);
    chk("t6_rst_cnt", 16'(cnt2), 16'h0);
    Resetn = 1'b1;
    tick();
    chk("t6_idle", 16'(busy2), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
